// File: rtl/gshare_predictor_param.sv
// Parametrised gshare direction predictor with a tagged, direct-mapped BTB.
// Fetch-side prediction is combinational; training and history repair arrive
// from EX and take effect at the next clock edge.
module gshare_predictor_param #(
    parameter int unsigned PHT_IDX_W = 5,
    parameter int unsigned HIST_LEN  = 5,
    parameter int unsigned BTB_IDX_W = 5,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned TAG_W     = 30 - BTB_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    output logic [31:0]          pred_next_pc,
    output logic                 pred_taken,
    output logic [PHT_IDX_W-1:0] pred_pht_index,
    output logic [HIST_LEN-1:0]  pred_ghr,
    input  logic                 upd_valid,
    input  logic                 upd_is_branch,
    input  logic                 upd_is_jump,
    input  logic [31:0]          upd_pc,
    input  logic [31:0]          upd_target,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    input  logic [PHT_IDX_W-1:0] upd_pht_index,
    input  logic [HIST_LEN-1:0]  upd_ghr
);

    localparam int unsigned PHT_N = 1 << PHT_IDX_W;
    localparam int unsigned BTB_N = 1 << BTB_IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    logic [HIST_LEN-1:0] ghr;
    logic [CTR_W-1:0]    pht        [PHT_N];
    logic [BTB_N-1:0]    btb_valid;
    logic [BTB_N-1:0]    btb_is_jump;
    logic [TAG_W-1:0]    btb_tag    [BTB_N];
    logic [31:0]         btb_target [BTB_N];

    logic [BTB_IDX_W-1:0] f_btb_idx;
    logic [TAG_W-1:0]     f_tag;
    logic                 f_hit;
    logic [PHT_IDX_W-1:0] f_pht_idx;

    logic                 u_jump;
    logic                 u_branch;
    logic                 repair;
    logic                 btb_we;
    logic                 spec_shift;
    logic [BTB_IDX_W-1:0] u_btb_idx;
    logic [TAG_W-1:0]     u_tag;
    logic [HIST_LEN-1:0]  ghr_next;
    logic [CTR_W-1:0]     ctr_cur;
    logic [CTR_W-1:0]     ctr_next;

    // Byte-offset bits of the resolved PC carry no information for indexing.
    logic unused_upd_pc_lsb;
    assign unused_upd_pc_lsb = ^upd_pc[1:0];

    // Fetch-side lookup: gshare index, BTB tag match and next-PC select.
    always_comb begin
        f_pht_idx      = fetch_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
        f_btb_idx      = fetch_pc[BTB_IDX_W+1:2];
        f_tag          = TAG_W'(fetch_pc[31:BTB_IDX_W+2]);
        f_hit          = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
        pred_taken     = f_hit && (btb_is_jump[f_btb_idx] || pht[f_pht_idx][CTR_W-1]);
        pred_next_pc   = pred_taken ? btb_target[f_btb_idx] : fetch_pc + 32'd4;
        pred_pht_index = f_pht_idx;
        pred_ghr       = ghr;
    end

    // Resolution decode; a jump flag wins over a branch flag.
    always_comb begin
        u_jump     = upd_valid && upd_is_jump;
        u_branch   = upd_valid && upd_is_branch && !upd_is_jump;
        repair     = upd_valid && upd_mispredict;
        btb_we     = u_jump || (u_branch && upd_taken);
        spec_shift = fetch_valid && f_hit && !btb_is_jump[f_btb_idx];
        u_btb_idx  = upd_pc[BTB_IDX_W+1:2];
        u_tag      = TAG_W'(upd_pc[31:BTB_IDX_W+2]);
    end

    // Next history: repair from the pipelined snapshot beats the speculative shift.
    always_comb begin
        ghr_next = ghr;
        if (repair) begin
            if (u_branch) begin
                ghr_next = HIST_LEN'({upd_ghr, upd_taken});
            end else begin
                ghr_next = upd_ghr;
            end
        end else if (spec_shift) begin
            ghr_next = HIST_LEN'({ghr, pred_taken});
        end
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        ctr_cur  = pht[upd_pht_index];
        ctr_next = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0) ctr_next = ctr_cur - CTR_W'(1);
        end
    end

    // Predictor state: history, PHT counters and BTB entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr         <= '0;
            btb_valid   <= '0;
            btb_is_jump <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else begin
            ghr <= ghr_next;
            if (u_branch) begin
                pht[upd_pht_index] <= ctr_next;
            end
            if (btb_we) begin
                btb_valid[u_btb_idx]   <= 1'b1;
                btb_is_jump[u_btb_idx] <= u_jump;
                btb_tag[u_btb_idx]     <= u_tag;
                btb_target[u_btb_idx]  <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Scoreboard bench for gshare_predictor_param: directed scenarios plus random
// traffic checked against an arithmetic reference model of the predictor.
module tb_gshare_predictor_param;

    localparam int unsigned P  = 5;
    localparam int unsigned H  = 5;
    localparam int unsigned B  = 5;
    localparam int unsigned C  = 2;
    localparam int unsigned PHT_N = 1 << P;
    localparam int unsigned BTB_N = 1 << B;
    localparam int unsigned HN    = 1 << H;
    localparam int CTR_HALF = 1 << (C - 1);
    localparam int CTR_TOP  = (1 << C) - 1;

    logic         clk;
    logic         reset;
    logic         fetch_valid;
    logic [31:0]  fetch_pc;
    logic [31:0]  pred_next_pc;
    logic         pred_taken;
    logic [P-1:0] pred_pht_index;
    logic [H-1:0] pred_ghr;
    logic         upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_mispredict;
    logic [31:0]  upd_pc, upd_target;
    logic [P-1:0] upd_pht_index;
    logic [H-1:0] upd_ghr;

    // second instance with non-default geometry
    logic        r2, d2_fv, d2_uv, d2_ub, d2_uj, d2_ut, d2_um, d2_tk;
    logic [31:0] d2_fpc, d2_upc, d2_utgt, d2_npc;
    logic [7:0]  d2_uidx, d2_idx;
    logic [5:0]  d2_ughr, d2_ghr;

    gshare_predictor_param #(.PHT_IDX_W(P), .HIST_LEN(H), .BTB_IDX_W(B), .CTR_W(C)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_next_pc(pred_next_pc), .pred_taken(pred_taken),
        .pred_pht_index(pred_pht_index), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_pht_index(upd_pht_index), .upd_ghr(upd_ghr)
    );

    gshare_predictor_param #(.PHT_IDX_W(8), .HIST_LEN(6), .BTB_IDX_W(5), .CTR_W(3)) dut2 (
        .clk(clk), .reset(r2), .fetch_valid(d2_fv), .fetch_pc(d2_fpc),
        .pred_next_pc(d2_npc), .pred_taken(d2_tk),
        .pred_pht_index(d2_idx), .pred_ghr(d2_ghr),
        .upd_valid(d2_uv), .upd_is_branch(d2_ub), .upd_is_jump(d2_uj),
        .upd_pc(d2_upc), .upd_target(d2_utgt), .upd_taken(d2_ut),
        .upd_mispredict(d2_um), .upd_pht_index(d2_uidx), .upd_ghr(d2_ughr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit           tk;
        logic [31:0]  npc;
        logic [P-1:0] idx;
        logic [H-1:0] ghr;
    } exp_t;

    exp_t q[$];
    exp_t e0;
    int total = 0;
    int bad   = 0;

    // reference model state
    int unsigned m_ghr;
    int          m_ctr [PHT_N];
    bit          m_v   [BTB_N];
    bit          m_j   [BTB_N];
    int unsigned m_tag [BTB_N];
    int unsigned m_tgt [BTB_N];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit tk, input logic [31:0] npc,
                                input logic [P-1:0] idx, input logic [H-1:0] ghr);
        exp_t e;
        e.tk = tk; e.npc = npc; e.idx = idx; e.ghr = ghr;
        return e;
    endfunction

    task automatic model_reset();
        m_ghr = 0;
        for (int i = 0; i < int'(PHT_N); i++) m_ctr[i] = CTR_HALF - 1;
        for (int i = 0; i < int'(BTB_N); i++) m_v[i] = 1'b0;
    endtask

    // Predict from current model state, queue the expectation, advance model, clock.
    task automatic tick_x(input bit uc, input exp_t ce);
        int unsigned pc, pidx, bi, ui, b2;
        bit hit, tk, jmp, br;
        exp_t e;
        pc   = fetch_pc;
        pidx = ((pc >> 2) % PHT_N) ^ m_ghr;
        bi   = (pc >> 2) % BTB_N;
        hit  = m_v[bi] && (m_tag[bi] == (pc >> (B + 2)));
        tk   = hit && (m_j[bi] || m_ctr[pidx] >= CTR_HALF);
        e = mk(tk, tk ? m_tgt[bi] : pc + 4, P'(pidx), H'(m_ghr));
        if (fetch_valid) q.push_back(uc ? ce : e);
        if (reset) begin
            model_reset();
        end else begin
            jmp = upd_valid && upd_is_jump;
            br  = upd_valid && upd_is_branch && !upd_is_jump;
            if (upd_valid && upd_mispredict)
                m_ghr = br ? (int'(upd_ghr) * 2 + int'(upd_taken)) % HN : int'(upd_ghr);
            else if (fetch_valid && hit && !m_j[bi])
                m_ghr = (m_ghr * 2 + int'(tk)) % HN;
            if (br) begin
                ui = upd_pht_index;
                if (upd_taken) m_ctr[ui] = (m_ctr[ui] == CTR_TOP) ? CTR_TOP : m_ctr[ui] + 1;
                else           m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end
            if (jmp || (br && upd_taken)) begin
                b2 = (int'(upd_pc) >> 2) % BTB_N;
                m_v[b2]   = 1'b1;
                m_j[b2]   = jmp;
                m_tag[b2] = upd_pc >> (B + 2);
                m_tgt[b2] = upd_target;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_x(1'b0, e0);
    endtask

    task automatic tick_c(input bit tk, input logic [31:0] npc,
                          input logic [P-1:0] idx, input logic [H-1:0] ghr);
        tick_x(1'b1, mk(tk, npc, idx, ghr));
    endtask

    task automatic clr();
        reset = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
        upd_valid = 1'b0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        upd_pht_index = '0; upd_ghr = '0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_valid = 1'b1; fetch_pc = pc;
    endtask

    task automatic upd(input bit br, input bit j, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit tk, input bit mp, input logic [P-1:0] idx, input logic [H-1:0] g);
        upd_valid = 1'b1; upd_is_branch = br; upd_is_jump = j; upd_pc = pc;
        upd_target = tgt; upd_taken = tk; upd_mispredict = mp;
        upd_pht_index = idx; upd_ghr = g;
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] r;
        r = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 3) == 0) r = r + 32'h1000;
        return r;
    endfunction

    // Monitor: every presented fetch is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fetch_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty: fetch presented with no expectation at %0t", $time);
                end else begin
                    e = q.pop_front();
                    cmp("pred_taken",     32'(pred_taken),     32'(e.tk));
                    cmp("pred_next_pc",   pred_next_pc,        e.npc);
                    cmp("pred_pht_index", 32'(pred_pht_index), 32'(e.idx));
                    cmp("pred_ghr",       32'(pred_ghr),       32'(e.ghr));
                end
            end
        end
    end

    initial begin
        int k;
        e0 = mk(1'b0, '0, '0, '0);
        r2 = 1'b1; d2_fv = 1'b0; d2_fpc = '0; d2_uv = 1'b0; d2_ub = 1'b0; d2_uj = 1'b0;
        d2_upc = '0; d2_utgt = '0; d2_ut = 1'b0; d2_um = 1'b0; d2_uidx = '0; d2_ughr = '0;
        model_reset();
        clr();
        reset = 1'b1;
        tick();
        tick();

        // reset state; jal resolved in the same cycle is not yet visible
        clr(); fetch(32'h40); upd(1'b0, 1'b1, 32'h40, 32'h100, 1'b1, 1'b1, 5'd16, 5'd0);
        tick_c(1'b0, 32'h44, 5'd16, 5'd0);
        clr(); fetch(32'h40);
        tick_c(1'b1, 32'h100, 5'd16, 5'd0);

        // train counter 8 to saturation and counter 9 to strongly taken
        clr(); upd(1'b1, 1'b0, 32'h20, 32'h80, 1'b1, 1'b0, 5'd8, 5'd0); tick();
        tick(); tick();
        clr(); upd(1'b1, 1'b0, 32'h20, 32'h80, 1'b1, 1'b0, 5'd9, 5'd0); tick(); tick();
        clr(); fetch(32'h20);
        tick_c(1'b1, 32'h80, 5'd8, 5'd0);
        clr(); fetch(32'h20);
        tick_c(1'b1, 32'h80, 5'd9, 5'd1);
        // repair overrides the speculative shift from ghr=00011
        clr(); fetch(32'h20); upd(1'b1, 1'b0, 32'h20, 32'h80, 1'b0, 1'b1, 5'd31, 5'b10100);
        tick_c(1'b0, 32'h24, 5'd11, 5'd3);
        clr(); fetch(32'h40);
        tick_c(1'b1, 32'h100, 5'd24, 5'd8);

        // aliasing branch evicts the 0x20 entry
        clr(); upd(1'b1, 1'b0, 32'hA0, 32'h200, 1'b1, 1'b0, 5'd31, 5'd0); tick();
        clr(); fetch(32'h20);
        tick_c(1'b0, 32'h24, 5'd0, 5'd8);

        // reset drops a same-cycle update and clears the BTB
        clr(); reset = 1'b1; upd(1'b0, 1'b1, 32'h60, 32'h300, 1'b1, 1'b1, 5'd8, 5'd3); tick();
        clr(); fetch(32'h60);
        tick_c(1'b0, 32'h64, 5'd24, 5'd0);
        clr(); fetch(32'h40);
        tick_c(1'b0, 32'h44, 5'd16, 5'd0);

        // floor saturation and jumps never training the PHT
        clr(); upd(1'b1, 1'b0, 32'h20, 32'h80, 1'b1, 1'b0, 5'd30, 5'd0); tick();
        clr(); upd(1'b1, 1'b0, 32'h20, 32'h80, 1'b0, 1'b0, 5'd8, 5'd0); tick(); tick();
        clr(); upd(1'b0, 1'b1, 32'h60, 32'h300, 1'b1, 1'b0, 5'd8, 5'd0); tick(); tick();
        clr(); fetch(32'h20);
        tick_c(1'b0, 32'h24, 5'd8, 5'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            clr();
            reset          = ($urandom_range(0, 199) == 0);
            fetch_valid    = ($urandom_range(0, 3) != 0);
            fetch_pc       = rpc();
            upd_valid      = $urandom_range(0, 1);
            k              = $urandom_range(0, 3);
            upd_is_branch  = (k == 1) || (k == 3);
            upd_is_jump    = (k >= 2);
            upd_pc         = rpc();
            upd_target     = $urandom;
            upd_target[1:0] = 2'b00;
            upd_taken      = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            upd_mispredict = ($urandom_range(0, 3) == 0);
            upd_pht_index  = P'($urandom);
            upd_ghr        = H'($urandom);
            tick();
        end

        // non-default geometry: 3-bit counters reset to 3, index from pc[9:2]
        clr();
        tick();
        r2 = 1'b0; d2_fv = 1'b1; d2_fpc = 32'h3FC;
        d2_uv = 1'b1; d2_ub = 1'b1; d2_upc = 32'h20; d2_utgt = 32'h80; d2_ut = 1'b1;
        d2_uidx = 8'd8; d2_ughr = 6'd0;
        #3;
        cmp("d2_pht_index", 32'(d2_idx), 32'hFF);
        cmp("d2_taken",     32'(d2_tk),  32'h0);
        cmp("d2_next_pc",   d2_npc,      32'h400);
        cmp("d2_ghr",       32'(d2_ghr), 32'h0);
        tick();
        d2_uv = 1'b0; d2_fpc = 32'h20;
        #3;
        cmp("d2_taken_after_one_inc", 32'(d2_tk), 32'h1);
        cmp("d2_target",              d2_npc,     32'h80);
        cmp("d2_pht_index_8",         32'(d2_idx), 32'h8);
        tick();
        d2_fv = 1'b0;

        tick(); tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
